stream_packet_sink: RTL and testbench
=====================================

// Module: stream_packet_sink
// PURPOSE
//  AXI-Stream slave that sits directly downstream of the counter stream source.
//  Drives tready, accepts beats and accumulates beat count and data sum per packet (tlast-delimited).
//  Presents a per-packet result record on a valid/ack handshake.
//  Back-pressures the stream while a result is waiting to be taken.
// PARAMETERS
//  DATA_W  3  stream tdata width
//  LEN_W   6  packet length counter width; saturates at 2**LEN_W-1
//  SUM_W   9  packet sum width; wraps modulo 2**SUM_W
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  en           in   1       sink enable; 0 = stop accepting beats (state retained)
//  s_tvalid     in   1       stream beat valid
//  s_tlast      in   1       last beat of packet
//  s_tdata      in   DATA_W  beat data
//  s_tready     out  1       sink ready
//  pkt_valid    out  1       result record valid
//  pkt_ack      in   1       result consumed (taken when pkt_valid & pkt_ack)
//  pkt_len      out  LEN_W   beats in packet, including the tlast beat
//  pkt_sum      out  SUM_W   sum of tdata over the packet
//  pkt_ovf      out  1       length saturated during the packet
//  pkt_seq_err  out  1       sequence error seen during the packet (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; s_tready=0 during rst; pkt_valid, pkt_len, pkt_sum, pkt_ovf, pkt_seq_err = 0.
//  - s_tready = en & (state != REPORT); combinational from registered state.
//  - Beat accepted when s_tvalid & s_tready; nothing else advances counters.
//  - FSM states:
//      IDLE   -> RECV    on accepted beat with s_tlast=0
//      IDLE   -> REPORT  on accepted beat with s_tlast=1 (1-beat packet)
//      RECV   -> REPORT  on accepted beat with s_tlast=1
//      REPORT -> IDLE    when pkt_ack=1
//  - First beat of a packet (in IDLE) loads len=1, sum=tdata, ovf=0, seq_err=0.
//  - Later beats: len+1 (saturating; ovf=1 once an increment is blocked), sum+=zero-extended tdata.
//  - Latency: pkt_valid=1 in the cycle after the tlast beat is accepted.
//  - In REPORT: pkt_valid held 1, record fields stable, s_tready=0.
//  - Ack cycle: pkt_valid=0 on the next edge; s_tready returns in that same next cycle (IDLE).
//  - pkt_ack while pkt_valid=0 is ignored.
//  - pkt_len/pkt_sum/pkt_ovf/pkt_seq_err hold their last values after ack until the next packet reports.
//  - en=0 mid-packet: no acceptance, counters frozen; resumes the same packet when en=1.
//  - en=0 in REPORT: no effect on the result handshake.
//  - rst mid-packet: partial packet discarded, no record produced.
//  - s_tdata/s_tlast are ignored when the beat is not accepted.
// CONFIGURATION
//  SEQ_CHECK_EN defined:
//    - Each non-first beat must equal previous accepted tdata + 1 mod 2**DATA_W.
//    - A mismatch sets the packet's seq_err sticky until the next packet's first beat.
//  SEQ_CHECK_EN undefined:
//    - No previous-data register; pkt_seq_err is tied to 0 (port always present).
// TESTING
//  1 beats 0,1,2,3,4, tlast on the 5th, tvalid continuous, pkt_ack=1
//      -> pkt_valid one cycle after last beat, len=5, sum=10, ovf=0, seq_err=0.
//  2 40 beats counting 0..7 repeated five times, tlast on beat 40
//      -> len=40, sum=140, seq_err=0.
//  3 pkt_ack held 0 for 10 cycles after a report, upstream tvalid=1
//      -> s_tready=0 all 10 cycles, record stable, no beats lost.
//      -> After ack, s_tready=1 the next cycle.
//  4 en=0 for 5 cycles mid-packet, plus tvalid gaps, 8 beats total
//      -> len=8 exactly; no acceptance while en=0.
//  5 70 beats of tdata=7, tlast on the 70th -> len=63, ovf=1, sum=490.
//  6a rst after 3 beats of a packet, then beats 0,1 with tlast
//      -> no record for the partial packet; next record len=2, sum=1.
//  6b beats 0,1,3 with tlast (SEQ_CHECK_EN defined) -> seq_err=1.
//  6c beats 0,1,3 with tlast (SEQ_CHECK_EN undefined) -> seq_err=0.

Source files
------------

// File: rtl/stream_packet_sink.sv
// rtl/stream_packet_sink.sv - stream sink that reports per-packet beat count and data sum
// Optional feature macro: SEQ_CHECK_EN (counter-sequence checking on non-first beats).
module stream_packet_sink #(
  parameter int DATA_W = 3,
  parameter int LEN_W  = 6,
  parameter int SUM_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              s_tready,
  output logic              pkt_valid,
  input  logic              pkt_ack,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [SUM_W-1:0]  pkt_sum,
  output logic              pkt_ovf,
  output logic              pkt_seq_err
);

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [SUM_W-1:0]   sum, sum_nxt;
  logic               ovf, ovf_nxt;
  logic               accept;
  logic               first;

  assign s_tready = en & ~rst & (state != REPORT);
  assign accept   = s_tvalid & s_tready;
  assign first    = (state == IDLE);

  always_comb begin
    len_nxt = len;
    sum_nxt = sum;
    ovf_nxt = ovf;
    if (first) begin
      len_nxt = LEN_W'(1);
      sum_nxt = SUM_W'(s_tdata);
      ovf_nxt = 1'b0;
    end else begin
      // Length saturates at all-ones; the first blocked increment flags overflow.
      if (len == {LEN_W{1'b1}}) begin
        ovf_nxt = 1'b1;
      end else begin
        len_nxt = len + LEN_W'(1);
      end
      sum_nxt = sum + SUM_W'(s_tdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      sum       <= '0;
      ovf       <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_len   <= '0;
      pkt_sum   <= '0;
      pkt_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, RECV: begin
          if (accept) begin
            len <= len_nxt;
            sum <= sum_nxt;
            ovf <= ovf_nxt;
            if (s_tlast) begin
              state     <= REPORT;
              pkt_valid <= 1'b1;
              pkt_len   <= len_nxt;
              pkt_sum   <= sum_nxt;
              pkt_ovf   <= ovf_nxt;
            end else begin
              state <= RECV;
            end
          end
        end
        REPORT: begin
          if (pkt_ack) begin
            state     <= IDLE;
            pkt_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_CHECK_EN
  logic [DATA_W-1:0] prev_data;
  logic              seq_err, seq_nxt;

  // Upstream is a counter source: each non-first beat must be previous + 1, wrapping.
  always_comb begin
    seq_nxt = 1'b0;
    if (!first) begin
      seq_nxt = seq_err | (s_tdata != DATA_W'(prev_data + DATA_W'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_data   <= '0;
      seq_err     <= 1'b0;
      pkt_seq_err <= 1'b0;
    end else if (accept) begin
      prev_data <= s_tdata;
      seq_err   <= seq_nxt;
      if (s_tlast) begin
        pkt_seq_err <= seq_nxt;
      end
    end
  end
`else
  assign pkt_seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_packet_sink.sv
// tb/tb_stream_packet_sink.sv - scoreboard bench for stream_packet_sink
module tb_stream_packet_sink;

  logic       clk = 1'b0;
  logic       rst, en, s_tvalid, s_tlast, s_tready;
  logic [2:0] s_tdata;
  logic       pkt_valid, pkt_ack, pkt_ovf, pkt_seq_err;
  logic [5:0] pkt_len;
  logic [8:0] pkt_sum;

`ifdef SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] len;
    logic [8:0] sum;
    logic       ovf;
    logic       seq;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_rec;
  int   checks = 0;
  int   errors = 0;
  int   n_pushed = 0;
  int   n_seen = 0;

  stream_packet_sink dut (
    .clk(clk), .rst(rst), .en(en),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tready(s_tready),
    .pkt_valid(pkt_valid), .pkt_ack(pkt_ack),
    .pkt_len(pkt_len), .pkt_sum(pkt_sum), .pkt_ovf(pkt_ovf), .pkt_seq_err(pkt_seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int len, input int sum, input logic ovf, input logic seq);
    rec_t r;
    r.len = 6'(len);
    r.sum = 9'(sum);
    r.ovf = ovf;
    r.seq = seq;
    exp_q.push_back(r);
    n_pushed++;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic beat(input logic [2:0] d, input logic last);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    #1;
    while (!s_tready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("beat_accept", s_tready, 1);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Monitor: inputs only change at the falling edge, so +2 reflects the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst && pkt_valid && pkt_ack) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_record", pkt_len, 0);
        check("unexpected_record_valid", pkt_valid, 0);
      end else begin
        mon_rec = exp_q.pop_front();
        check("pkt_len", pkt_len, mon_rec.len);
        check("pkt_sum", pkt_sum, mon_rec.sum);
        check("pkt_ovf", pkt_ovf, mon_rec.ovf);
        check("pkt_seq_err", pkt_seq_err, mon_rec.seq);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; pkt_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tready", s_tready, 0);
    check("rst_valid", pkt_valid, 0);
    check("rst_len", pkt_len, 0);
    check("rst_sum", pkt_sum, 0);
    check("rst_ovf", pkt_ovf, 0);
    check("rst_seq", pkt_seq_err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_tready", s_tready, 1);
    @(negedge clk);

    // 1: five counting beats, ack already high
    push(5, 10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) beat(3'(i), i == 4);
    #1;
    check("t1_latency_valid", pkt_valid, 1);
    check("t1_report_tready", s_tready, 0);
    @(negedge clk);
    #1;
    check("t1_after_ack_valid", pkt_valid, 0);
    check("t1_after_ack_tready", s_tready, 1);
    @(negedge clk);

    // 2: 0..7 five times
    push(40, 140, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) beat(3'(i % 8), i == 39);
    @(negedge clk);

    // 3: result held for 10 cycles while upstream keeps offering a beat
    pkt_ack = 1'b0;
    push(4, 6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) beat(3'(i), i == 3);
    s_tvalid = 1'b1; s_tdata = 3'd0; s_tlast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3_stall_tready", s_tready, 0);
      check("t3_stall_valid", pkt_valid, 1);
      check("t3_stable_len", pkt_len, 4);
      check("t3_stable_sum", pkt_sum, 6);
      @(negedge clk);
    end
    pkt_ack = 1'b1;
    @(negedge clk);
    #1;
    check("t3_ack_valid", pkt_valid, 0);
    check("t3_ack_tready", s_tready, 1);
    push(3, 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) beat(3'(i), i == 2);
    @(negedge clk);

    // 4: enable dropped mid-packet, plus tvalid gaps
    push(8, 28, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) beat(3'(i), 1'b0);
    en = 1'b0; s_tvalid = 1'b1; s_tdata = 3'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_en_off_tready", s_tready, 0);
      @(negedge clk);
    end
    en = 1'b1;
    for (int i = 3; i < 8; i++) begin
      beat(3'(i), i == 7);
      if (i % 2 == 1) repeat (2) @(negedge clk);
    end
    @(negedge clk);

    // 5: 70 beats of 7 saturate the length
    push(63, 490, 1'b1, SEQ_ON);
    for (int i = 0; i < 70; i++) beat(3'd7, i == 69);
    @(negedge clk);

    // 6a: reset discards a partial packet
    for (int i = 0; i < 3; i++) beat(3'(i), 1'b0);
    rst = 1'b1;
    #1;
    check("t6a_rst_tready", s_tready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6a_no_record", pkt_valid, 0);
    @(negedge clk);
    push(2, 1, 1'b0, 1'b0);
    beat(3'd0, 1'b0);
    beat(3'd1, 1'b1);
    @(negedge clk);

    // 6b/6c: broken sequence
    push(3, 4, 1'b0, SEQ_ON);
    beat(3'd0, 1'b0);
    beat(3'd1, 1'b0);
    beat(3'd3, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("record_count", n_seen, n_pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
